// File: rtl/gpio_bank.sv
// Multi-group bidirectional GPIO bank: per-pin direction, byte-writable output data,
// synchronised inputs with edge-triggered sticky status and one aggregated, registered irq.
module gpio_bank #(
  parameter int GROUPS      = 4,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter bit BOTH_EDGES  = 1'b0,
  localparam int SW = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int NB = WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [SW-1:0]             sel,
  input  logic [1:0]                addr,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [NB-1:0]             write_byte,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      irq,
  inout  wire  [GROUPS*WIDTH-1:0]   io_pin
);

  localparam int CW = $clog2(SYNC_STAGES + 1) + 1;

  typedef enum logic {PRIME = 1'b0, ARMED = 1'b1} arm_state_e;

  logic [WIDTH-1:0] dout_q   [GROUPS];
  logic [WIDTH-1:0] dout_d   [GROUPS];
  logic [WIDTH-1:0] dir_q    [GROUPS];
  logic [WIDTH-1:0] dir_d    [GROUPS];
  logic [WIDTH-1:0] mask_q   [GROUPS];
  logic [WIDTH-1:0] mask_d   [GROUPS];
  logic [WIDTH-1:0] status_q [GROUPS];
  logic [WIDTH-1:0] status_d [GROUPS];
  logic [WIDTH-1:0] prev_q   [GROUPS];
  logic [WIDTH-1:0] prev_d   [GROUPS];
  logic [WIDTH-1:0] sync_q   [GROUPS][SYNC_STAGES];
  logic [WIDTH-1:0] sync_d   [GROUPS][SYNC_STAGES];

  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             irq_q, irq_d;
  arm_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] byte_mask;
  logic             sel_ok;
  logic             hit;
  logic             any_irq;
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rd_val;

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    assign byte_mask[gi*8 +: 8] = {8{write_byte[gi]}};
  end

  // Pins are released purely from dir_q, so an asynchronous reset floats them at once.
  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
    for (genvar bi = 0; bi < WIDTH; bi++) begin : g_pin
      assign io_pin[gi*WIDTH + bi] = dir_q[gi][bi] ? dout_q[gi][bi] : 1'bz;
    end
  end

  assign sel_ok = (32'(sel) < 32'(GROUPS));
  assign rdata  = rdata_q;
  assign irq    = irq_q;

  always_comb begin
    hit       = 1'b0;
    any_irq   = 1'b0;
    sync_last = '0;
    evt       = '0;
    w1c       = '0;
    rd_val    = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;

    for (int g = 0; g < GROUPS; g++) begin
      dout_d[g] = dout_q[g];
      dir_d[g]  = dir_q[g];
      mask_d[g] = mask_q[g];
      w1c       = '0;
      hit       = wr_en && sel_ok && (sel == SW'(g));
      if (hit) begin
        case (addr)
          2'd0:    dout_d[g] = (dout_q[g] & ~byte_mask) | (wdata & byte_mask);
          2'd1:    dir_d[g]  = (dir_q[g]  & ~byte_mask) | (wdata & byte_mask);
          2'd2:    mask_d[g] = (mask_q[g] & ~byte_mask) | (wdata & byte_mask);
          default: w1c       = wdata & byte_mask;
        endcase
      end

      sync_d[g][0] = io_pin[g*WIDTH +: WIDTH];
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_d[g][s] = sync_q[g][s-1];
      end
      sync_last = sync_q[g][SYNC_STAGES-1];
      prev_d[g] = sync_last;

      evt = BOTH_EDGES ? (sync_last ^ prev_q[g]) : (sync_last & ~prev_q[g]);
      if (state_q != ARMED) begin
        evt = '0;
      end
      // Set wins over a same-cycle W1C so no event is ever lost.
      status_d[g] = (status_q[g] & ~w1c) | evt;

      if (|(status_q[g] & mask_q[g])) begin
        any_irq = 1'b1;
      end

      if (sel_ok && (sel == SW'(g))) begin
        case (addr)
          2'd0:    rd_val = sync_last;
          2'd1:    rd_val = dir_q[g];
          2'd2:    rd_val = mask_q[g];
          default: rd_val = status_q[g];
        endcase
      end
    end

    rdata_d = rd_en ? rd_val : rdata_q;
    irq_d   = any_irq;

    // Hold off edge detection until the synchronisers and prev hold real pin levels.
    if (state_q == PRIME) begin
      if (cnt_q == CW'(SYNC_STAGES)) begin
        state_d = ARMED;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int g = 0; g < GROUPS; g++) begin
        dout_q[g]   <= '0;
        dir_q[g]    <= '0;
        mask_q[g]   <= '0;
        status_q[g] <= '0;
        prev_q[g]   <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[g][s] <= '0;
        end
      end
      rdata_q <= '0;
      irq_q   <= 1'b0;
      state_q <= PRIME;
      cnt_q   <= '0;
    end else begin
      for (int g = 0; g < GROUPS; g++) begin
        dout_q[g]   <= dout_d[g];
        dir_q[g]    <= dir_d[g];
        mask_q[g]   <= mask_d[g];
        status_q[g] <= status_d[g];
        prev_q[g]   <= prev_d[g];
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[g][s] <= sync_d[g][s];
        end
      end
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: a 4x32 rising-edge bank plus a 3x8 both-edges bank
// that exercises out-of-range group selects.
module tb_gpio_bank;

  logic         clk = 1'b0;
  logic         RST = 1'b1;

  logic [1:0]   sel = '0, addr = '0;
  logic         wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]   write_byte = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         irq;
  wire  [127:0] pins;
  logic [127:0] tb_oe = '0, tb_out = '0;

  logic [1:0]   sel2 = '0, addr2 = '0;
  logic         wr_en2 = 1'b0, rd_en2 = 1'b0;
  logic [0:0]   wb2 = '0;
  logic [7:0]   wdata2 = '0;
  logic [7:0]   rdata2;
  logic         irq2;
  wire  [23:0]  pins2;
  logic [23:0]  oe2 = '0, out2 = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic [7:0]  rd8;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 128; gi++) begin : g_drv1
    assign pins[gi] = tb_oe[gi] ? tb_out[gi] : 1'bz;
  end
  for (genvar gi = 0; gi < 24; gi++) begin : g_drv2
    assign pins2[gi] = oe2[gi] ? out2[gi] : 1'bz;
  end

  gpio_bank #(.GROUPS(4), .WIDTH(32), .SYNC_STAGES(2), .BOTH_EDGES(1'b0)) u_dut (
    .clk(clk), .RST(RST), .sel(sel), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .write_byte(write_byte), .wdata(wdata), .rdata(rdata), .irq(irq), .io_pin(pins)
  );

  gpio_bank #(.GROUPS(3), .WIDTH(8), .SYNC_STAGES(2), .BOTH_EDGES(1'b1)) u_dut2 (
    .clk(clk), .RST(RST), .sel(sel2), .addr(addr2), .wr_en(wr_en2), .rd_en(rd_en2),
    .write_byte(wb2), .wdata(wdata2), .rdata(rdata2), .irq(irq2), .io_pin(pins2)
  );

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic wr1(input logic [1:0] s, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    @(negedge clk);
    sel = s; addr = a; wdata = d; write_byte = be; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd1(input logic [1:0] s, input logic [1:0] a, output logic [31:0] q);
    @(negedge clk);
    sel = s; addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    q = rdata;
  endtask

  task automatic wr2(input logic [1:0] s, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    sel2 = s; addr2 = a; wdata2 = d; wb2 = 1'b1; wr_en2 = 1'b1;
    @(negedge clk);
    wr_en2 = 1'b0;
  endtask

  task automatic rd2(input logic [1:0] s, input logic [1:0] a, output logic [7:0] q);
    @(negedge clk);
    sel2 = s; addr2 = a; rd_en2 = 1'b1;
    @(negedge clk);
    rd_en2 = 1'b0;
    q = rdata2;
  endtask

  initial begin
    vecs[0] = '{"dir_all",    2'd0, 2'd1, 32'hFFFFFFFF, 4'b1111, 32'hFFFFFFFF};
    vecs[1] = '{"dout_all",   2'd0, 2'd0, 32'hA5A5A5A5, 4'b1111, 32'hA5A5A5A5};
    vecs[2] = '{"dout_b02",   2'd0, 2'd0, 32'h00000000, 4'b0101, 32'hA500A500};
    vecs[3] = '{"dout_b3",    2'd0, 2'd0, 32'hFFFFFFFF, 4'b1000, 32'hFF00A500};
    vecs[4] = '{"stat_rd",    2'd0, 2'd3, 32'h00000000, 4'b1111, 32'hFFA5A5A5};
    vecs[5] = '{"stat_w1c",   2'd0, 2'd3, 32'h0000FFFF, 4'b0011, 32'hFFA50000};
    vecs[6] = '{"mask_lo",    2'd0, 2'd2, 32'h0000FFFF, 4'b0011, 32'h0000FFFF};
    vecs[7] = '{"mask_nobe",  2'd0, 2'd2, 32'hFFFFFFFF, 4'b0000, 32'h0000FFFF};
    vecs[8] = '{"mask_g3",    2'd3, 2'd2, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
    vecs[9] = '{"dir_hi_clr", 2'd0, 2'd1, 32'h00000000, 4'b1100, 32'h0000FFFF};

    // Reset state and asynchronous reset while driving
    repeat (2) @(negedge clk);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata2", {24'd0, rdata2}, 32'd0);
    RST = 1'b0;
    wr1(2'd0, 2'd1, 32'hFFFFFFFF, 4'hF);
    wr1(2'd0, 2'd0, 32'hA5A5A5A5, 4'hF);
    wr1(2'd0, 2'd2, 32'hFFFFFFFF, 4'hF);
    repeat (4) @(negedge clk);
    rd1(2'd0, 2'd0, rd);
    chk("t1_drive", pins[31:0], 32'hA5A5A5A5);
    chk("t1_rd", rd, 32'hA5A5A5A5);
    chk("t1_irq_on", {31'd0, irq}, 32'd1);
    @(negedge clk);
    #2 RST = 1'b1;
    #1;
    chk("t1_irq_async", {31'd0, irq}, 32'd0);
    chk("t1_rdata_async", rdata, 32'd0);
    tb_oe[31:0] = '1;
    tb_out[31:0] = 32'h5A5A5A5A;
    #1;
    chk("t1_pins_z", pins[31:0], 32'h5A5A5A5A);
    tb_oe = '0;
    tb_out = '0;
    @(negedge clk);
    RST = 1'b0;

    // Register table
    for (int i = 0; i < 10; i++) begin
      wr1(vecs[i].sel, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      repeat (3) @(negedge clk);
      rd1(vecs[i].sel, vecs[i].addr, rd);
      chk(vecs[i].name, rd, vecs[i].exp);
    end
    chk("tbl_irq_off", {31'd0, irq}, 32'd0);

    // Byte-enabled direction and data on group 1; upper half floats
    tb_oe[63:48] = '1;
    tb_out[63:48] = 16'hABCD;
    wr1(2'd1, 2'd1, 32'hFFFFFFFF, 4'b0011);
    wr1(2'd1, 2'd0, 32'h00001234, 4'b0011);
    repeat (3) @(negedge clk);
    chk("t2_pins_lo", {16'd0, pins[47:32]}, 32'h00001234);
    chk("t2_pins_hi", {16'd0, pins[63:48]}, 32'h0000ABCD);
    rd1(2'd1, 2'd0, rd);
    chk("t2_readback", rd, 32'hABCD1234);
    rd1(2'd1, 2'd1, rd);
    chk("t2_dir", rd, 32'h0000FFFF);

    // Priming: pins held high through reset release must not raise status
    tb_oe = '0;
    tb_out = '0;
    tb_oe[103] = 1'b1;
    tb_out[103] = 1'b1;
    oe2[23] = 1'b1;
    out2[23] = 1'b1;
    @(negedge clk);
    RST = 1'b1;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    repeat (8) @(negedge clk);
    rd1(2'd3, 2'd3, rd);
    chk("t5_prime_status", rd, 32'h0);
    rd1(2'd3, 2'd0, rd);
    chk("t5_prime_sync", rd, 32'h00000080);
    rd2(2'd2, 2'd3, rd8);
    chk("t5_prime2_status", {24'd0, rd8}, 32'h0);
    tb_out[103] = 1'b0;
    out2[23] = 1'b0;
    repeat (4) @(negedge clk);
    rd2(2'd2, 2'd3, rd8);
    chk("t5_fall_both", {24'd0, rd8}, 32'h00000080);
    rd1(2'd3, 2'd3, rd);
    chk("t5_fall_rise_only", rd, 32'h0);
    tb_out[103] = 1'b1;
    repeat (4) @(negedge clk);
    rd1(2'd3, 2'd3, rd);
    chk("t5_rearm", rd, 32'h00000080);

    // IRQ latency on g2[0] and W1C release
    tb_oe[64] = 1'b1;
    tb_out[64] = 1'b0;
    wr1(2'd2, 2'd2, 32'h00000001, 4'hF);
    repeat (3) @(negedge clk);
    sel = 2'd2; addr = 2'd3; rd_en = 1'b1;
    tb_out[64] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("t3_irq_e2", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("t3_stat_e3_prev", rdata, 32'd0);
    chk("t3_irq_e3", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("t3_stat_e3", rdata, 32'd1);
    chk("t3_irq_e4", {31'd0, irq}, 32'd1);
    @(negedge clk);
    rd_en = 1'b0;
    wdata = 32'h00000001; write_byte = 4'hF; wr_en = 1'b1;
    @(posedge clk); #1;
    chk("t3_irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    chk("t3_irq_clr", {31'd0, irq}, 32'd0);

    // Event and W1C collide on g0[5]
    tb_oe[5] = 1'b1;
    tb_out[5] = 1'b0;
    wr1(2'd0, 2'd2, 32'h00000020, 4'hF);
    tb_out[5] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_pre_irq", {31'd0, irq}, 32'd1);
    tb_out[5] = 1'b0;
    repeat (5) @(negedge clk);
    tb_out[5] = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    sel = 2'd0; addr = 2'd3; wdata = 32'h00000020; write_byte = 4'hF; wr_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_coll_irq", {31'd0, irq}, 32'd1);
    rd1(2'd0, 2'd3, rd);
    chk("t4_coll_status", rd, 32'h00000020);

    // Out-of-range group select on the 3-group bank
    wr2(2'd0, 2'd2, 8'h11);
    wr2(2'd1, 2'd2, 8'h22);
    wr2(2'd2, 2'd2, 8'h33);
    for (int a = 0; a < 4; a++) begin
      wr2(2'd3, 2'(a), 8'hFF);
    end
    for (int a = 0; a < 4; a++) begin
      rd2(2'd3, 2'(a), rd8);
      chk($sformatf("t6_oor_rd_a%0d", a), {24'd0, rd8}, 32'h0);
    end
    for (int g = 0; g < 3; g++) begin
      rd2(2'(g), 2'd2, rd8);
      chk($sformatf("t6_mask_g%0d", g), {24'd0, rd8}, 32'(8'h11 * (g + 1)));
    end
    rd2(2'd2, 2'd3, rd8);
    chk("t6_status_g2", {24'd0, rd8}, 32'h00000080);
    rd2(2'd1, 2'd1, rd8);
    chk("t6_dir_g1", {24'd0, rd8}, 32'h0);
    chk("t6_irq2", {31'd0, irq2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
